// File: rtl/occamy_cva6_ctrl_pkg.sv
// Shared types, register offsets and FSM states for the CVA6 host control block.
package occamy_cva6_ctrl_pkg;

    typedef logic [63:0] xlen_t;

    // Register map, byte offsets; every register is 64 bits wide and 8-byte aligned.
    localparam logic [5:0] REG_CTRL      = 6'h00;
    localparam logic [5:0] REG_BOOT_ADDR = 6'h08;
    localparam logic [5:0] REG_MSIP      = 6'h10;
    localparam logic [5:0] REG_MTIME     = 6'h18;
    localparam logic [5:0] REG_MTIMECMP  = 6'h20;
    localparam logic [5:0] REG_DEBUG     = 6'h28;

    // Register index; register idx lives at byte offset idx*8.
    localparam int unsigned NUM_REGS      = 6;
    localparam int unsigned IDX_CTRL      = 0;
    localparam int unsigned IDX_BOOT_ADDR = 1;
    localparam int unsigned IDX_MSIP      = 2;
    localparam int unsigned IDX_MTIME     = 3;
    localparam int unsigned IDX_MTIMECMP  = 4;
    localparam int unsigned IDX_DEBUG     = 5;

    // Core reset sequencing states.
    typedef enum logic [1:0] {
        HELD    = 2'd0,
        RELEASE = 2'd1,
        RUNNING = 2'd2
    } state_e;

    // Byte offset of register index idx.
    function automatic logic [5:0] reg_offset(input int unsigned idx);
        return 6'(idx * 8);
    endfunction

endpackage

// File: rtl/occamy_cva6_ctrl_timer.sv
// Machine timer: mtime counter advanced by RTC ticks, mtimecmp, and registered compare.
module occamy_cva6_ctrl_timer
    import occamy_cva6_ctrl_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  rtc_tick,
    input  logic  mtime_we,
    input  logic  mtimecmp_we,
    input  xlen_t wdata,
    output xlen_t mtime,
    output xlen_t mtimecmp,
    output logic  time_irq
);

    xlen_t mtime_reg;
    xlen_t mtime_next;
    xlen_t mtimecmp_reg;
    xlen_t mtimecmp_next;
    logic  time_irq_reg;

    // Next timer values; a software write to mtime overrides a coincident tick.
    always_comb begin
        mtime_next    = mtime_reg;
        mtimecmp_next = mtimecmp_reg;
        if (mtime_we) begin
            mtime_next = wdata;
        end else if (rtc_tick) begin
            mtime_next = mtime_reg + 64'd1;
        end
        if (mtimecmp_we) begin
            mtimecmp_next = wdata;
        end
    end

    // Timer state and interrupt register; compare uses the values before this edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mtime_reg    <= '0;
            mtimecmp_reg <= '1;
            time_irq_reg <= 1'b0;
        end else begin
            mtime_reg    <= mtime_next;
            mtimecmp_reg <= mtimecmp_next;
            time_irq_reg <= (mtime_reg >= mtimecmp_reg);
        end
    end

    assign mtime    = mtime_reg;
    assign mtimecmp = mtimecmp_reg;
    assign time_irq = time_irq_reg;

endmodule

// File: rtl/occamy_cva6_ctrl.sv
// Per-hart CVA6 control: core reset sequencing, boot address, IPI, timer and debug request.
module occamy_cva6_ctrl
    import occamy_cva6_ctrl_pkg::*;
#(
    parameter xlen_t       BootAddrDefault = 64'h1_0000,
    parameter int unsigned ResetCycles     = 16,
    parameter logic        AutoBoot        = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        reg_req_valid_i,
    output logic        reg_req_ready_o,
    input  logic        reg_req_write_i,
    input  logic [5:0]  reg_req_addr_i,
    input  logic [63:0] reg_req_wdata_i,
    output logic        reg_rsp_valid_o,
    input  logic        reg_rsp_ready_i,
    output logic [63:0] reg_rsp_rdata_o,
    output logic        reg_rsp_error_o,
    input  logic        rtc_tick_i,
    output logic        core_rst_no,
    output logic [63:0] boot_addr_o,
    output logic        ipi_o,
    output logic        time_irq_o,
    output logic        debug_req_o
);

    localparam logic [7:0] CNT_LOAD = 8'(ResetCycles - 1);

    // Register bus
    logic [NUM_REGS-1:0] reg_hit;
    logic                addr_valid;
    logic                accept;
    logic                wr_accept;
    logic                access_error;
    xlen_t               read_data;

    logic                rsp_valid_reg;
    logic                rsp_valid_next;
    xlen_t               rsp_rdata_reg;
    xlen_t               rsp_rdata_next;
    logic                rsp_error_reg;
    logic                rsp_error_next;

    // Control registers
    logic                run_reg;
    logic                run_next;
    xlen_t               boot_addr_reg;
    xlen_t               boot_addr_next;
    logic                msip_reg;
    logic                msip_next;
    logic                debug_reg;
    logic                debug_next;
    logic                ipi_reg;
    logic                debug_req_reg;

    // Reset FSM
    state_e              state_reg;
    state_e              state_next;
    logic [7:0]          cnt_reg;
    logic [7:0]          cnt_next;
    logic                core_rst_n_reg;

    // Timer
    xlen_t               mtime;
    xlen_t               mtimecmp;
    logic                time_irq;

    // Address decode: a full 6-bit match also rejects misaligned offsets.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
        assign reg_hit[gi] = (reg_req_addr_i == reg_offset(gi));
    end

    assign addr_valid      = |reg_hit;
    assign reg_req_ready_o = !rsp_valid_reg || reg_rsp_ready_i;
    assign accept          = reg_req_valid_i && reg_req_ready_o;
    assign wr_accept       = accept && reg_req_write_i && addr_valid;

    // Error on unmapped offsets and on boot address writes once the core left HELD.
    always_comb begin
        access_error = !addr_valid;
        if (reg_req_write_i && reg_hit[IDX_BOOT_ADDR] && (state_reg != HELD)) begin
            access_error = 1'b1;
        end
    end

    // Read mux on current register contents (value before the accept edge).
    always_comb begin
        read_data = '0;
        if (reg_hit[IDX_CTRL]) begin
            read_data = {62'd0, (state_reg == RUNNING), run_reg};
        end
        if (reg_hit[IDX_BOOT_ADDR]) begin
            read_data = boot_addr_reg;
        end
        if (reg_hit[IDX_MSIP]) begin
            read_data = {63'd0, msip_reg};
        end
        if (reg_hit[IDX_MTIME]) begin
            read_data = mtime;
        end
        if (reg_hit[IDX_MTIMECMP]) begin
            read_data = mtimecmp;
        end
        if (reg_hit[IDX_DEBUG]) begin
            read_data = {63'd0, debug_reg};
        end
    end

    // Response channel: capture on accept, hold until the consumer takes it.
    always_comb begin
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_error_next = rsp_error_reg;
        if (accept) begin
            rsp_valid_next = 1'b1;
            rsp_rdata_next = reg_req_write_i ? '0 : read_data;
            rsp_error_next = access_error;
        end else if (reg_rsp_ready_i) begin
            rsp_valid_next = 1'b0;
        end
    end

    // Software-visible control register updates.
    always_comb begin
        run_next       = run_reg;
        boot_addr_next = boot_addr_reg;
        msip_next      = msip_reg;
        debug_next     = debug_reg;
        if (wr_accept && !access_error) begin
            if (reg_hit[IDX_CTRL]) begin
                run_next = reg_req_wdata_i[0];
            end
            if (reg_hit[IDX_BOOT_ADDR]) begin
                boot_addr_next = reg_req_wdata_i;
            end
            if (reg_hit[IDX_MSIP]) begin
                msip_next = reg_req_wdata_i[0];
            end
            if (reg_hit[IDX_DEBUG]) begin
                debug_next = reg_req_wdata_i[0];
            end
        end
    end

    // Core reset sequencing: HELD -> RELEASE (count down) -> RUNNING; clearing run aborts.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            HELD: begin
                if (run_reg) begin
                    state_next = RELEASE;
                    cnt_next   = CNT_LOAD;
                end
            end
            RELEASE: begin
                if (!run_reg) begin
                    state_next = HELD;
                end else if (cnt_reg == 8'd0) begin
                    state_next = RUNNING;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            RUNNING: begin
                if (!run_reg) begin
                    state_next = HELD;
                end
            end
            default: begin
                state_next = HELD;
            end
        endcase
    end

    // State registers; run resets to AutoBoot so an auto-booting core leaves HELD right after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_reg  <= 1'b0;
            rsp_rdata_reg  <= '0;
            rsp_error_reg  <= 1'b0;
            run_reg        <= AutoBoot;
            boot_addr_reg  <= BootAddrDefault;
            msip_reg       <= 1'b0;
            debug_reg      <= 1'b0;
            ipi_reg        <= 1'b0;
            debug_req_reg  <= 1'b0;
            state_reg      <= HELD;
            cnt_reg        <= '0;
            core_rst_n_reg <= 1'b0;
        end else begin
            rsp_valid_reg  <= rsp_valid_next;
            rsp_rdata_reg  <= rsp_rdata_next;
            rsp_error_reg  <= rsp_error_next;
            run_reg        <= run_next;
            boot_addr_reg  <= boot_addr_next;
            msip_reg       <= msip_next;
            debug_reg      <= debug_next;
            ipi_reg        <= msip_reg;
            debug_req_reg  <= debug_reg;
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            core_rst_n_reg <= (state_next == RUNNING);
        end
    end

    occamy_cva6_ctrl_timer u_timer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rtc_tick    (rtc_tick_i),
        .mtime_we    (wr_accept && reg_hit[IDX_MTIME]),
        .mtimecmp_we (wr_accept && reg_hit[IDX_MTIMECMP]),
        .wdata       (reg_req_wdata_i),
        .mtime       (mtime),
        .mtimecmp    (mtimecmp),
        .time_irq    (time_irq)
    );

    assign reg_rsp_valid_o = rsp_valid_reg;
    assign reg_rsp_rdata_o = rsp_rdata_reg;
    assign reg_rsp_error_o = rsp_error_reg;
    assign core_rst_no     = core_rst_n_reg;
    assign boot_addr_o     = boot_addr_reg;
    assign ipi_o           = ipi_reg;
    assign time_irq_o      = time_irq;
    assign debug_req_o     = debug_req_reg;

endmodule

// File: tb/tb_occamy_cva6_ctrl.sv
// Directed bench for occamy_cva6_ctrl: reset sequencing, register bus, timer and interrupts.
module tb_occamy_cva6_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        reg_req_valid_i = 1'b0;
    logic        reg_req_ready_o;
    logic        reg_req_write_i = 1'b0;
    logic [5:0]  reg_req_addr_i = '0;
    logic [63:0] reg_req_wdata_i = '0;
    logic        reg_rsp_valid_o;
    logic        reg_rsp_ready_i = 1'b1;
    logic [63:0] reg_rsp_rdata_o;
    logic        reg_rsp_error_o;
    logic        rtc_tick_i = 1'b0;
    logic        core_rst_no;
    logic [63:0] boot_addr_o;
    logic        ipi_o;
    logic        time_irq_o;
    logic        debug_req_o;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned accept_cyc = 0;
    logic        rsp_seen;

    occamy_cva6_ctrl #(
        .BootAddrDefault (64'h1_0000),
        .ResetCycles     (16),
        .AutoBoot        (1'b0)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .reg_req_valid_i (reg_req_valid_i),
        .reg_req_ready_o (reg_req_ready_o),
        .reg_req_write_i (reg_req_write_i),
        .reg_req_addr_i  (reg_req_addr_i),
        .reg_req_wdata_i (reg_req_wdata_i),
        .reg_rsp_valid_o (reg_rsp_valid_o),
        .reg_rsp_ready_i (reg_rsp_ready_i),
        .reg_rsp_rdata_o (reg_rsp_rdata_o),
        .reg_rsp_error_o (reg_rsp_error_o),
        .rtc_tick_i      (rtc_tick_i),
        .core_rst_no     (core_rst_no),
        .boot_addr_o     (boot_addr_o),
        .ipi_o           (ipi_o),
        .time_irq_o      (time_irq_o),
        .debug_req_o     (debug_req_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // One bus transaction with the response consumed immediately; prints one line.
    task automatic bus(input logic wr, input logic [5:0] addr, input logic [63:0] wdata,
                       output logic [63:0] rdata, output logic err);
        int n;
        @(negedge clk_i);
        reg_req_valid_i = 1'b1;
        reg_req_write_i = wr;
        reg_req_addr_i  = addr;
        reg_req_wdata_i = wdata;
        reg_rsp_ready_i = 1'b1;
        n = 0;
        while (!reg_req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i);
        #1;
        accept_cyc      = cyc;
        reg_req_valid_i = 1'b0;
        rsp_seen        = reg_rsp_valid_o;
        rdata           = reg_rsp_rdata_o;
        err             = reg_rsp_error_o;
        $display("txn wr=%0d addr=%02h wdata=%016h rdata=%016h err=%0d rsp=%0d",
                 wr, addr, wdata, rdata, err, rsp_seen);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        total++;
        if (core_rst_no !== 1'b0 || ipi_o !== 1'b0 || time_irq_o !== 1'b0 ||
            debug_req_o !== 1'b0 || reg_rsp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: rst=%b ipi=%b tirq=%b dbg=%b rspv=%b required 0 0 0 0 0",
                     core_rst_no, ipi_o, time_irq_o, debug_req_o, reg_rsp_valid_o);
        end
        total++;
        if (boot_addr_o !== 64'h1_0000) begin
            bad++;
            $display("FAIL reset_boot_addr: got %h required %h", boot_addr_o, 64'h1_0000);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (50) @(posedge clk_i);
        #1;
        total++;
        if (core_rst_no !== 1'b0 || time_irq_o !== 1'b0 || boot_addr_o !== 64'h1_0000) begin
            bad++;
            $display("FAIL idle_held: rst=%b tirq=%b boot=%h required 0 0 10000",
                     core_rst_no, time_irq_o, boot_addr_o);
        end
    endtask

    task automatic test_boot();
        logic [63:0] rd;
        logic        er;
        int          lat;
        bus(1'b1, 6'h08, 64'h8000_0000, rd, er);
        total++;
        if (er !== 1'b0 || rsp_seen !== 1'b1) begin
            bad++;
            $display("FAIL boot_addr_write: err=%b rsp=%b required 0 1", er, rsp_seen);
        end
        @(posedge clk_i);
        #1;
        total++;
        if (boot_addr_o !== 64'h8000_0000) begin
            bad++;
            $display("FAIL boot_addr_out: got %h required %h", boot_addr_o, 64'h8000_0000);
        end
        bus(1'b1, 6'h00, 64'h1, rd, er);
        lat = 0;
        while (core_rst_no !== 1'b1 && lat < 100) begin
            @(posedge clk_i);
            #1;
            lat = int'(cyc - accept_cyc);
        end
        total++;
        if (lat != 17) begin
            bad++;
            $display("FAIL release_latency: got %0d cycles required 17", lat);
        end
        bus(1'b0, 6'h00, 64'h0, rd, er);
        total++;
        if (rd !== 64'h3 || er !== 1'b0) begin
            bad++;
            $display("FAIL ctrl_read_running: got %h err=%b required 3 err=0", rd, er);
        end
    endtask

    task automatic test_running_locks();
        logic [63:0] rd;
        logic        er;
        bus(1'b1, 6'h08, 64'h1234_5678, rd, er);
        total++;
        if (er !== 1'b1) begin
            bad++;
            $display("FAIL boot_write_running_err: got %b required 1", er);
        end
        @(posedge clk_i);
        #1;
        total++;
        if (boot_addr_o !== 64'h8000_0000) begin
            bad++;
            $display("FAIL boot_addr_locked: got %h required %h", boot_addr_o, 64'h8000_0000);
        end
        bus(1'b1, 6'h00, 64'h0, rd, er);
        @(posedge clk_i);
        #1;
        total++;
        if (core_rst_no !== 1'b0) begin
            bad++;
            $display("FAIL stop_core: rst=%b required 0", core_rst_no);
        end
        bus(1'b0, 6'h00, 64'h0, rd, er);
        total++;
        if (rd !== 64'h0) begin
            bad++;
            $display("FAIL ctrl_read_held: got %h required 0", rd);
        end
    endtask

    task automatic test_timer_irq();
        logic [63:0] rd;
        logic        er;
        bus(1'b1, 6'h20, 64'd5, rd, er);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            rtc_tick_i = 1'b1;
            @(posedge clk_i);
            #1;
            rtc_tick_i = 1'b0;
        end
        total++;
        if (time_irq_o !== 1'b0) begin
            bad++;
            $display("FAIL tirq_latency: got %b required 0 on the edge mtime reaches 5", time_irq_o);
        end
        @(posedge clk_i);
        #1;
        total++;
        if (time_irq_o !== 1'b1) begin
            bad++;
            $display("FAIL tirq_set: got %b required 1", time_irq_o);
        end
        bus(1'b0, 6'h18, 64'h0, rd, er);
        total++;
        if (rd !== 64'd5) begin
            bad++;
            $display("FAIL mtime_after_ticks: got %h required 5", rd);
        end
        bus(1'b1, 6'h20, '1, rd, er);
        @(posedge clk_i);
        #1;
        total++;
        if (time_irq_o !== 1'b0) begin
            bad++;
            $display("FAIL tirq_clear: got %b required 0", time_irq_o);
        end
    endtask

    task automatic test_mtime_wrap();
        logic [63:0] rd;
        logic        er;
        bus(1'b1, 6'h18, '1, rd, er);
        @(negedge clk_i);
        rtc_tick_i = 1'b1;
        @(posedge clk_i);
        #1;
        rtc_tick_i = 1'b0;
        bus(1'b0, 6'h18, 64'h0, rd, er);
        total++;
        if (rd !== 64'h0) begin
            bad++;
            $display("FAIL mtime_wrap: got %h required 0", rd);
        end
        // Write and tick in the same cycle.
        @(negedge clk_i);
        reg_req_valid_i = 1'b1;
        reg_req_write_i = 1'b1;
        reg_req_addr_i  = 6'h18;
        reg_req_wdata_i = 64'd7;
        reg_rsp_ready_i = 1'b1;
        rtc_tick_i      = 1'b1;
        @(posedge clk_i);
        #1;
        reg_req_valid_i = 1'b0;
        rtc_tick_i      = 1'b0;
        $display("txn wr=1 addr=18 wdata=%016h with tick", 64'd7);
        bus(1'b0, 6'h18, 64'h0, rd, er);
        total++;
        if (rd !== 64'd7) begin
            bad++;
            $display("FAIL mtime_write_wins: got %h required 7", rd);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        reg_req_valid_i = 1'b1;
        reg_req_write_i = 1'b1;
        reg_req_addr_i  = 6'h10;
        reg_req_wdata_i = 64'h1;
        reg_rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        $display("txn wr=1 addr=10 wdata=%016h rdata=%016h err=%0d", 64'h1, reg_rsp_rdata_o, reg_rsp_error_o);
        total++;
        if (reg_rsp_valid_o !== 1'b1 || reg_rsp_error_o !== 1'b0 || reg_rsp_rdata_o !== 64'h0) begin
            bad++;
            $display("FAIL b2b_write_rsp: v=%b e=%b d=%h required 1 0 0",
                     reg_rsp_valid_o, reg_rsp_error_o, reg_rsp_rdata_o);
        end
        reg_req_write_i = 1'b0;
        @(posedge clk_i);
        #1;
        reg_req_valid_i = 1'b0;
        $display("txn wr=0 addr=10 rdata=%016h err=%0d", reg_rsp_rdata_o, reg_rsp_error_o);
        total++;
        if (reg_rsp_valid_o !== 1'b1 || reg_rsp_rdata_o !== 64'h1) begin
            bad++;
            $display("FAIL b2b_read_rsp: v=%b d=%h required 1 1", reg_rsp_valid_o, reg_rsp_rdata_o);
        end
        total++;
        if (ipi_o !== 1'b1) begin
            bad++;
            $display("FAIL ipi_set: got %b required 1", ipi_o);
        end
    endtask

    task automatic test_debug();
        logic [63:0] rd;
        logic        er;
        bus(1'b1, 6'h28, 64'h1, rd, er);
        @(posedge clk_i);
        #1;
        total++;
        if (debug_req_o !== 1'b1) begin
            bad++;
            $display("FAIL debug_set: got %b required 1", debug_req_o);
        end
        bus(1'b1, 6'h28, 64'h0, rd, er);
        @(posedge clk_i);
        #1;
        total++;
        if (debug_req_o !== 1'b0) begin
            bad++;
            $display("FAIL debug_clear: got %b required 0", debug_req_o);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] rd;
        logic        er;
        @(negedge clk_i);
        reg_req_valid_i = 1'b1;
        reg_req_write_i = 1'b0;
        reg_req_addr_i  = 6'h10;
        reg_rsp_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        reg_req_valid_i = 1'b0;
        $display("txn wr=0 addr=10 held rdata=%016h", reg_rsp_rdata_o);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            total++;
            if (reg_rsp_valid_o !== 1'b1 || reg_rsp_rdata_o !== 64'h1 ||
                reg_req_ready_o !== 1'b0 || ipi_o !== 1'b1) begin
                bad++;
                $display("FAIL rsp_hold[%0d]: v=%b d=%h rdy=%b ipi=%b required 1 1 0 1",
                         i, reg_rsp_valid_o, reg_rsp_rdata_o, reg_req_ready_o, ipi_o);
            end
        end
        reg_rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        total++;
        if (reg_rsp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rsp_drain: v=%b required 0", reg_rsp_valid_o);
        end
        bus(1'b0, 6'h30, 64'h0, rd, er);
        total++;
        if (er !== 1'b1 || rd !== 64'h0) begin
            bad++;
            $display("FAIL bad_offset: err=%b d=%h required 1 0", er, rd);
        end
        bus(1'b1, 6'h0C, 64'hFFFF, rd, er);
        total++;
        if (er !== 1'b1) begin
            bad++;
            $display("FAIL misaligned: err=%b required 1", er);
        end
    endtask

    task automatic test_reset_mid_release();
        logic [63:0] rd;
        logic        er;
        bus(1'b1, 6'h00, 64'h1, rd, er);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reg_req_valid_i = 1'b1;
        reg_req_write_i = 1'b0;
        reg_req_addr_i  = 6'h00;
        reg_rsp_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        reg_req_valid_i = 1'b0;
        $display("txn wr=0 addr=00 pending rdata=%016h", reg_rsp_rdata_o);
        total++;
        if (reg_rsp_valid_o !== 1'b1 || reg_rsp_rdata_o !== 64'h1) begin
            bad++;
            $display("FAIL release_pending: v=%b d=%h required 1 1", reg_rsp_valid_o, reg_rsp_rdata_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        total++;
        if (reg_rsp_valid_o !== 1'b0 || core_rst_no !== 1'b0 || boot_addr_o !== 64'h1_0000) begin
            bad++;
            $display("FAIL reset_mid_release: v=%b rst=%b boot=%h required 0 0 10000",
                     reg_rsp_valid_o, core_rst_no, boot_addr_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        reg_rsp_ready_i = 1'b1;
        bus(1'b0, 6'h00, 64'h0, rd, er);
        total++;
        if (rd !== 64'h0) begin
            bad++;
            $display("FAIL ctrl_after_reset: got %h required 0", rd);
        end
        repeat (20) @(posedge clk_i);
        #1;
        total++;
        if (core_rst_no !== 1'b0) begin
            bad++;
            $display("FAIL stays_held: rst=%b required 0", core_rst_no);
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_running_locks();
        test_timer_irq();
        test_mtime_wrap();
        test_back_to_back();
        test_debug();
        test_backpressure();
        test_reset_mid_release();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
